// File: rtl/noc_ni_master.sv
// noc_ni_master: network-interface master for the router's local port.
// Injects single-flit requests tagged with a transaction ID taken from a
// free pool, and returns the matching responses to the local initiator.
module noc_ni_master #(
    parameter int DX_W   = 2,
    parameter int DY_W   = 2,
    parameter int CUR_X  = 0,
    parameter int CUR_Y  = 0,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic                   req_we,
    input  logic [DATA_W-1:0]      req_wdata,
    input  logic [DATA_W/8-1:0]    req_wstrb,
    output logic                   noc_tvalid,
    input  logic                   noc_tready,
    output logic [DATA_W-1:0]      noc_tdata,
    output logic [DATA_W/8-1:0]    noc_tstrb,
    output logic [DATA_W/8-1:0]    noc_tkeep,
    output logic                   noc_tlast,
    output logic [ID_W-1:0]        noc_tid,
    output logic [ADDR_W-1:0]      noc_tdest,
    output logic [DX_W+DY_W:0]     noc_tuser,
    input  logic                   rsp_tvalid,
    output logic                   rsp_tready,
    input  logic [DATA_W-1:0]      rsp_tdata,
    input  logic [ID_W-1:0]        rsp_tid,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic [ID_W:0]          outstanding,
    output logic                   err_unexp
);

    localparam int NUM_ID = 2 ** ID_W;
    localparam int NODE_W = DX_W + DY_W;
    localparam logic [NODE_W-1:0] OWN_NODE = {DY_W'(CUR_Y), DX_W'(CUR_X)};

    logic [NUM_ID-1:0] busy;
    logic [NUM_ID-1:0] busy_next;
    logic [ID_W-1:0]   alloc_id;
    logic [ID_W:0]     busy_count;
    logic [NODE_W-1:0] req_node;
    logic              pool_full;
    logic              req_fire;
    logic              rsp_beat;
    logic              rsp_hit;
    logic              own_node_unused;

    // Own-node traffic is injected like any other; the router turns it around.
    assign req_node        = req_addr[ADDR_W-1 -: NODE_W];
    assign own_node_unused = (req_node == OWN_NODE);

    assign pool_full  = &busy;
    assign req_ready  = !pool_full && (!noc_tvalid || noc_tready);
    assign req_fire   = req_valid && req_ready;
    assign rsp_tready = !rsp_valid || rsp_ready;
    assign rsp_beat   = rsp_tvalid && rsp_tready;
    assign rsp_hit    = rsp_beat && busy[rsp_tid];

    // Pick the lowest free ID from the current (pre-update) pool.
    always_comb begin
        alloc_id = '0;
        for (int i = NUM_ID - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_id = ID_W'(i);
        end
    end

    // Next pool state: set on allocation, clear on a matching response.
    always_comb begin
        busy_next = busy;
        if (req_fire) busy_next[alloc_id] = 1'b1;
        if (rsp_hit)  busy_next[rsp_tid]  = 1'b0;
        busy_count = '0;
        for (int i = 0; i < NUM_ID; i++) begin
            busy_count = busy_count + (ID_W+1)'(busy_next[i]);
        end
    end

    // ID pool, its population count and the sticky unexpected-response flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy        <= '0;
            outstanding <= '0;
            err_unexp   <= 1'b0;
        end else begin
            busy        <= busy_next;
            outstanding <= busy_count;
            if (rsp_beat && !busy[rsp_tid]) err_unexp <= 1'b1;
        end
    end

    // Request flit register; payload only changes when a new request is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            noc_tvalid <= 1'b0;
            noc_tdata  <= '0;
            noc_tstrb  <= '0;
            noc_tkeep  <= '0;
            noc_tlast  <= 1'b0;
            noc_tid    <= '0;
            noc_tdest  <= '0;
            noc_tuser  <= '0;
        end else if (req_fire) begin
            noc_tvalid <= 1'b1;
            noc_tdata  <= req_wdata;
            noc_tstrb  <= req_wstrb;
            noc_tkeep  <= '1;
            noc_tlast  <= 1'b1;
            noc_tid    <= alloc_id;
            noc_tdest  <= req_addr;
            noc_tuser  <= {req_we, req_node};
        end else if (noc_tready) begin
            noc_tvalid <= 1'b0;
        end
    end

    // Response register; unexpected beats are swallowed without touching it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else if (rsp_hit) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rsp_tdata;
            rsp_id    <= rsp_tid;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_noc_ni_master.sv
// tb_noc_ni_master: table-driven cycle vectors plus a reset/late-response sequence.
module tb_noc_ni_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        noc_tvalid;
    logic        noc_tready;
    logic [31:0] noc_tdata;
    logic [3:0]  noc_tstrb;
    logic [3:0]  noc_tkeep;
    logic        noc_tlast;
    logic [1:0]  noc_tid;
    logic [31:0] noc_tdest;
    logic [4:0]  noc_tuser;
    logic        rsp_tvalid;
    logic        rsp_tready;
    logic [31:0] rsp_tdata;
    logic [1:0]  rsp_tid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_id;
    logic [2:0]  outstanding;
    logic        err_unexp;

    int checks;
    int errors;

    noc_ni_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .noc_tvalid(noc_tvalid), .noc_tready(noc_tready), .noc_tdata(noc_tdata),
        .noc_tstrb(noc_tstrb), .noc_tkeep(noc_tkeep), .noc_tlast(noc_tlast),
        .noc_tid(noc_tid), .noc_tdest(noc_tdest), .noc_tuser(noc_tuser),
        .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tdata(rsp_tdata),
        .rsp_tid(rsp_tid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .outstanding(outstanding), .err_unexp(err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: inputs driven at the falling edge, expected outputs seen
    // before the following rising edge.
    typedef struct {
        logic        rv;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        nrdy;
        logic        rtv;
        logic [1:0]  rtid;
        logic [31:0] rtdata;
        logic        rrdy;
        logic        e_req_ready;
        logic        e_tvalid;
        logic [1:0]  e_tid;
        logic [4:0]  e_tuser;
        logic [31:0] e_tdata;
        logic [31:0] e_tdest;
        logic [3:0]  e_tstrb;
        logic        e_rsp_tready;
        logic        e_rsp_valid;
        logic [31:0] e_rsp_data;
        logic [1:0]  e_rsp_id;
        logic [2:0]  e_outstanding;
        logic        e_err;
    } vec_t;

    localparam int NVEC = 20;
    localparam logic [31:0] A0 = 32'h4000_0010;
    localparam logic [31:0] B  = 32'h8000_0004;

    vec_t vecs [NVEC];

    task automatic applyStimulus(input vec_t v);
        req_valid  = v.rv;
        req_addr   = v.addr;
        req_we     = v.we;
        req_wdata  = v.wdata;
        req_wstrb  = v.we ? 4'hF : 4'h0;
        noc_tready = v.nrdy;
        rsp_tvalid = v.rtv;
        rsp_tid    = v.rtid;
        rsp_tdata  = v.rtdata;
        rsp_ready  = v.rrdy;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic setIdle();
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_we     = 1'b0;
        req_wdata  = 32'h0;
        req_wstrb  = 4'h0;
        noc_tready = 1'b1;
        rsp_tvalid = 1'b0;
        rsp_tid    = 2'd0;
        rsp_tdata  = 32'h0;
        rsp_ready  = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            rv    addr   we    wdata          nrdy  rtv   rtid  rtdata          rrdy   | rq_rdy tv   tid   tuser  tdata          tdest  strb  rtrdy rsv   rdata           rid   out   err
        vecs[0]  = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 2'd0, 32'h0,          1'b1,   1'b1, 1'b0, 2'd0, 5'h00, 32'h0,         32'h0, 4'h0, 1'b1, 1'b0, 32'h0,          2'd0, 3'd0, 1'b0};
        vecs[1]  = '{1'b1, A0,    1'b0, 32'h0,         1'b1, 1'b0, 2'd0, 32'h0,          1'b1,   1'b1, 1'b0, 2'd0, 5'h00, 32'h0,         32'h0, 4'h0, 1'b1, 1'b0, 32'h0,          2'd0, 3'd0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 2'd0, 32'h1111_0000,  1'b1,   1'b1, 1'b1, 2'd0, 5'h04, 32'h0,         A0,    4'h0, 1'b1, 1'b0, 32'h0,          2'd0, 3'd1, 1'b0};
        vecs[3]  = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 2'd0, 32'h0,          1'b1,   1'b1, 1'b0, 2'd0, 5'h04, 32'h0,         A0,    4'h0, 1'b1, 1'b1, 32'h1111_0000,  2'd0, 3'd0, 1'b0};
        vecs[4]  = '{1'b1, B,     1'b1, 32'hA0,        1'b1, 1'b0, 2'd0, 32'h0,          1'b1,   1'b1, 1'b0, 2'd0, 5'h04, 32'h0,         A0,    4'h0, 1'b1, 1'b0, 32'h1111_0000,  2'd0, 3'd0, 1'b0};
        vecs[5]  = '{1'b1, B,     1'b1, 32'hA1,        1'b1, 1'b0, 2'd0, 32'h0,          1'b1,   1'b1, 1'b1, 2'd0, 5'h18, 32'hA0,        B,     4'hF, 1'b1, 1'b0, 32'h1111_0000,  2'd0, 3'd1, 1'b0};
        vecs[6]  = '{1'b1, B,     1'b1, 32'hA2,        1'b1, 1'b0, 2'd0, 32'h0,          1'b1,   1'b1, 1'b1, 2'd1, 5'h18, 32'hA1,        B,     4'hF, 1'b1, 1'b0, 32'h1111_0000,  2'd0, 3'd2, 1'b0};
        vecs[7]  = '{1'b1, B,     1'b1, 32'hA3,        1'b1, 1'b0, 2'd0, 32'h0,          1'b1,   1'b1, 1'b1, 2'd2, 5'h18, 32'hA2,        B,     4'hF, 1'b1, 1'b0, 32'h1111_0000,  2'd0, 3'd3, 1'b0};
        vecs[8]  = '{1'b1, B,     1'b1, 32'hA4,        1'b1, 1'b1, 2'd2, 32'h2222_2222,  1'b1,   1'b0, 1'b1, 2'd3, 5'h18, 32'hA3,        B,     4'hF, 1'b1, 1'b0, 32'h1111_0000,  2'd0, 3'd4, 1'b0};
        vecs[9]  = '{1'b1, B,     1'b1, 32'hA4,        1'b0, 1'b0, 2'd0, 32'h0,          1'b1,   1'b1, 1'b0, 2'd3, 5'h18, 32'hA3,        B,     4'hF, 1'b1, 1'b1, 32'h2222_2222,  2'd2, 3'd3, 1'b0};
        vecs[10] = '{1'b1, B,     1'b1, 32'hA5,        1'b0, 1'b1, 2'd1, 32'hDEAD_BEEF,  1'b0,   1'b0, 1'b1, 2'd2, 5'h18, 32'hA4,        B,     4'hF, 1'b1, 1'b0, 32'h2222_2222,  2'd2, 3'd4, 1'b0};
        vecs[11] = '{1'b1, B,     1'b1, 32'hA5,        1'b0, 1'b1, 2'd3, 32'h3333_3333,  1'b0,   1'b0, 1'b1, 2'd2, 5'h18, 32'hA4,        B,     4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF,  2'd1, 3'd3, 1'b0};
        vecs[12] = '{1'b1, B,     1'b1, 32'hA5,        1'b0, 1'b1, 2'd3, 32'h3333_3333,  1'b0,   1'b0, 1'b1, 2'd2, 5'h18, 32'hA4,        B,     4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF,  2'd1, 3'd3, 1'b0};
        vecs[13] = '{1'b1, B,     1'b1, 32'hA5,        1'b1, 1'b1, 2'd3, 32'h3333_3333,  1'b1,   1'b1, 1'b1, 2'd2, 5'h18, 32'hA4,        B,     4'hF, 1'b1, 1'b1, 32'hDEAD_BEEF,  2'd1, 3'd3, 1'b0};
        vecs[14] = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 2'd0, 32'h0,          1'b1,   1'b1, 1'b1, 2'd1, 5'h18, 32'hA5,        B,     4'hF, 1'b1, 1'b1, 32'h3333_3333,  2'd3, 3'd3, 1'b0};
        vecs[15] = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 2'd3, 32'h4444_4444,  1'b1,   1'b1, 1'b0, 2'd1, 5'h18, 32'hA5,        B,     4'hF, 1'b1, 1'b0, 32'h3333_3333,  2'd3, 3'd3, 1'b0};
        vecs[16] = '{1'b1, B,     1'b1, 32'hA6,        1'b1, 1'b0, 2'd0, 32'h0,          1'b1,   1'b1, 1'b0, 2'd1, 5'h18, 32'hA5,        B,     4'hF, 1'b1, 1'b0, 32'h3333_3333,  2'd3, 3'd3, 1'b1};
        vecs[17] = '{1'b1, B,     1'b1, 32'hA7,        1'b1, 1'b1, 2'd0, 32'h5555_5555,  1'b1,   1'b0, 1'b1, 2'd3, 5'h18, 32'hA6,        B,     4'hF, 1'b1, 1'b0, 32'h3333_3333,  2'd3, 3'd4, 1'b1};
        vecs[18] = '{1'b1, B,     1'b1, 32'hA7,        1'b1, 1'b0, 2'd0, 32'h0,          1'b1,   1'b1, 1'b0, 2'd3, 5'h18, 32'hA6,        B,     4'hF, 1'b1, 1'b1, 32'h5555_5555,  2'd0, 3'd3, 1'b1};
        vecs[19] = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 2'd0, 32'h0,          1'b1,   1'b0, 1'b1, 2'd0, 5'h18, 32'hA7,        B,     4'hF, 1'b1, 1'b0, 32'h5555_5555,  2'd0, 3'd4, 1'b1};

        setIdle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d.req_ready", i),   64'(req_ready),   64'(vecs[i].e_req_ready));
            checkOutput($sformatf("row%0d.noc_tvalid", i),  64'(noc_tvalid),  64'(vecs[i].e_tvalid));
            checkOutput($sformatf("row%0d.noc_tid", i),     64'(noc_tid),     64'(vecs[i].e_tid));
            checkOutput($sformatf("row%0d.noc_tuser", i),   64'(noc_tuser),   64'(vecs[i].e_tuser));
            checkOutput($sformatf("row%0d.noc_tdata", i),   64'(noc_tdata),   64'(vecs[i].e_tdata));
            checkOutput($sformatf("row%0d.noc_tdest", i),   64'(noc_tdest),   64'(vecs[i].e_tdest));
            checkOutput($sformatf("row%0d.noc_tstrb", i),   64'(noc_tstrb),   64'(vecs[i].e_tstrb));
            checkOutput($sformatf("row%0d.rsp_tready", i),  64'(rsp_tready),  64'(vecs[i].e_rsp_tready));
            checkOutput($sformatf("row%0d.rsp_valid", i),   64'(rsp_valid),   64'(vecs[i].e_rsp_valid));
            checkOutput($sformatf("row%0d.rsp_data", i),    64'(rsp_data),    64'(vecs[i].e_rsp_data));
            checkOutput($sformatf("row%0d.rsp_id", i),      64'(rsp_id),      64'(vecs[i].e_rsp_id));
            checkOutput($sformatf("row%0d.outstanding", i), 64'(outstanding), 64'(vecs[i].e_outstanding));
            checkOutput($sformatf("row%0d.err_unexp", i),   64'(err_unexp),   64'(vecs[i].e_err));
            if (vecs[i].e_tvalid) begin
                checkOutput($sformatf("row%0d.noc_tlast", i), 64'(noc_tlast), 64'(1'b1));
                checkOutput($sformatf("row%0d.noc_tkeep", i), 64'(noc_tkeep), 64'(4'hF));
            end
            @(negedge clk);
        end

        // Reset in the middle of a full pool: everything in flight is dropped.
        setIdle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midreset.req_ready",   64'(req_ready),   64'(1'b1));
        checkOutput("midreset.rsp_tready",  64'(rsp_tready),  64'(1'b1));
        checkOutput("midreset.noc_tvalid",  64'(noc_tvalid),  64'(1'b0));
        checkOutput("midreset.noc_tdata",   64'(noc_tdata),   64'(32'h0));
        checkOutput("midreset.noc_tuser",   64'(noc_tuser),   64'(5'h00));
        checkOutput("midreset.rsp_valid",   64'(rsp_valid),   64'(1'b0));
        checkOutput("midreset.outstanding", 64'(outstanding), 64'(3'd0));
        checkOutput("midreset.err_unexp",   64'(err_unexp),   64'(1'b0));

        // Own-node read is injected normally with the first free ID.
        req_valid = 1'b1;
        req_addr  = 32'h0000_0100;
        @(negedge clk);
        setIdle();
        #1;
        checkOutput("ownnode.noc_tvalid",  64'(noc_tvalid),  64'(1'b1));
        checkOutput("ownnode.noc_tid",     64'(noc_tid),     64'(2'd0));
        checkOutput("ownnode.noc_tuser",   64'(noc_tuser),   64'(5'h00));
        checkOutput("ownnode.noc_tdest",   64'(noc_tdest),   64'(32'h0000_0100));
        checkOutput("ownnode.noc_tlast",   64'(noc_tlast),   64'(1'b1));
        checkOutput("ownnode.noc_tkeep",   64'(noc_tkeep),   64'(4'hF));
        checkOutput("ownnode.outstanding", 64'(outstanding), 64'(3'd1));

        // Late response for an ID that the reset already retired.
        rsp_tvalid = 1'b1;
        rsp_tid    = 2'd2;
        rsp_tdata  = 32'h6666_6666;
        @(negedge clk);
        setIdle();
        #1;
        checkOutput("late.err_unexp",   64'(err_unexp),   64'(1'b1));
        checkOutput("late.rsp_valid",   64'(rsp_valid),   64'(1'b0));
        checkOutput("late.outstanding", 64'(outstanding), 64'(3'd1));
        @(negedge clk);
        #1;
        checkOutput("late.err_sticky",  64'(err_unexp),   64'(1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
